// File: rtl/gpio_debounce_irq_if.sv
// Signal bundle between raw board pins / core GPIO ports and the input conditioner.
interface gpio_debounce_irq_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] in_raw;
  logic [N_CH-1:0] irq_mask;
  logic [N_CH-1:0] irq_clear;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] irq_pending;
  logic            irq;

  modport master (
    output in_raw, irq_mask, irq_clear,
    input  level, rise, fall, irq_pending, irq
  );

  modport slave (
    input  in_raw, irq_mask, irq_clear,
    output level, rise, fall, irq_pending, irq
  );
endinterface

// File: rtl/gpio_debounce_irq.sv
// N-channel switch/key conditioner: synchroniser, polarity fix, counter debounce,
// edge pulses and sticky interrupt-pending flags with mask and clear.
module gpio_debounce_irq #(
  parameter int              N_CH            = 4,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter logic [N_CH-1:0] INVERT          = '0,
  parameter logic [N_CH-1:0] IRQ_RISE        = '1,
  parameter logic [N_CH-1:0] IRQ_FALL        = '0
) (
  input  logic               clock,
  input  logic               reset,
  gpio_debounce_irq_if.slave bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_CH-1:0]            sync0_q, sync0_d;
  logic [N_CH-1:0]            sync1_q, sync1_d;
  logic [N_CH-1:0]            level_q, level_d;
  logic [N_CH-1:0]            rise_q, rise_d;
  logic [N_CH-1:0]            fall_q, fall_d;
  logic [N_CH-1:0]            pending_q, pending_d;
  logic                       irq_q, irq_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]            samp;
  logic [N_CH-1:0]            pend_set;

  assign samp = sync1_q ^ INVERT;

  // Pending sets in the same cycle as the accepted edge, so irq and the flag rise together.
  always_comb begin
    sync0_d  = bus.in_raw;
    sync1_d  = sync0_q;
    level_d  = level_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (samp[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = samp[i];
        rise_d[i]  = samp[i];
        fall_d[i]  = ~samp[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    pend_set  = (rise_d & IRQ_RISE) | (fall_d & IRQ_FALL);
    pending_d = pend_set | (pending_q & ~bus.irq_clear);
    irq_d     = |(pending_d & bus.irq_mask);
  end

  // Synchroniser resets to INVERT so the corrected sample starts at 0 and no edge follows reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync0_q   <= INVERT;
      sync1_q   <= INVERT;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.level       = level_q;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.irq_pending = pending_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Bench for gpio_debounce_irq: vector table, timed corner sequences and random
// traffic checked against a sliding-window reference model.
module tb_gpio_debounce_irq;

  localparam int         N    = 4;
  localparam int         D    = 8;
  localparam logic [3:0] INV  = 4'b1000;
  localparam logic [3:0] IRQR = 4'b0111;
  localparam logic [3:0] IRQF = 4'b1001;

  logic clock = 1'b0;
  logic reset = 1'b0;

  gpio_debounce_irq_if #(.N_CH(N)) bus ();

  gpio_debounce_irq #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .INVERT(INV), .IRQ_RISE(IRQR), .IRQ_FALL(IRQF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: raw delay line plus a window of the last D corrected samples.
  logic [3:0] m_d0, m_d1, m_lvl, m_rise, m_fall, m_pend;
  logic       m_irq;
  logic [3:0] m_hist[$];

  typedef struct {
    logic [3:0] in_raw;
    logic [3:0] mask;
    logic [3:0] clr;
    int         cycles;
    logic [3:0] exp_level;
    logic [3:0] exp_pend;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[9];

  task automatic model_reset();
    m_d0 = INV; m_d1 = INV;
    m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic       all_diff;
    s = m_d1 ^ INV;
    m_hist.push_back(s);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      if (m_hist.size() == D) begin
        all_diff = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i]  = s[i];
          m_rise[i] = s[i];
          m_fall[i] = ~s[i];
        end
      end
    end
    m_pend = (m_rise & IRQR) | (m_fall & IRQF) | (m_pend & ~bus.irq_clear);
    m_irq  = |(m_pend & bus.irq_mask);
    m_d1 = m_d0;
    m_d0 = bus.in_raw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    check(name, {15'd0, bus.level, bus.rise, bus.fall, bus.irq_pending, bus.irq},
                {15'd0, m_lvl, m_rise, m_fall, m_pend, m_irq});
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
    checkOutput("model");
  endtask

  task automatic applyStimulus(input logic [3:0] in_raw, input logic [3:0] mask, input logic [3:0] clr);
    bus.in_raw    = in_raw;
    bus.irq_mask  = mask;
    bus.irq_clear = clr;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b1000, 4'b1111, 4'b0000, 12, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{4'b1001, 4'b1111, 4'b0000, 12, 4'b0001, 4'b0001, 1'b1};
    vecs[2] = '{4'b0001, 4'b1111, 4'b0000, 12, 4'b1001, 4'b0001, 1'b1};
    vecs[3] = '{4'b0001, 4'b1111, 4'b1111,  1, 4'b1001, 4'b0000, 1'b0};
    vecs[4] = '{4'b1001, 4'b1111, 4'b0000, 12, 4'b0001, 4'b1000, 1'b1};
    vecs[5] = '{4'b1000, 4'b0000, 4'b0000, 12, 4'b0000, 4'b1001, 1'b0};
    vecs[6] = '{4'b0110, 4'b0000, 4'b0000, 12, 4'b1110, 4'b1111, 1'b0};
    vecs[7] = '{4'b0110, 4'b0110, 4'b0000,  1, 4'b1110, 4'b1111, 1'b1};
    vecs[8] = '{4'b0110, 4'b0110, 4'b1111,  1, 4'b1110, 4'b0000, 1'b0};

    applyStimulus(4'b1000, 4'b1111, 4'b0000);
    do_reset();

    // Idle with key released: nothing may move.
    for (int c = 0; c < 50; c++) begin
      cycle();
      check("idle_outputs", {bus.level, bus.rise, bus.fall, bus.irq_pending, bus.irq}, 17'd0);
    end

    // Channel 0 rise accepted exactly at the tenth edge after the change.
    applyStimulus(4'b1001, 4'b1111, 4'b0000);
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("ch0_level", bus.level[0], n >= 10);
      check("ch0_rise", bus.rise[0], n == 10);
      check("ch0_irq", bus.irq, n >= 10);
    end

    // Channel 1 bounce of 5-cycle pulses must be rejected.
    for (int c = 0; c < 100; c++) begin
      applyStimulus((((c / 5) % 2) == 0) ? 4'b1011 : 4'b1001, 4'b1111, 4'b0000);
      cycle();
      check("ch1_glitch", {bus.level[1], bus.rise[1], bus.irq_pending[1]}, 3'b000);
    end
    applyStimulus(4'b1011, 4'b1111, 4'b0000);
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("ch1_level", bus.level[1], n >= 10);
    end

    // Channel 3 inverted key: press raises level, release produces a pending fall.
    applyStimulus(4'b0011, 4'b1111, 4'b0000);
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("ch3_press", {bus.level[3], bus.irq_pending[3]}, {n >= 10, 1'b0});
    end
    applyStimulus(4'b1011, 4'b1111, 4'b0000);
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("ch3_release", {bus.level[3], bus.fall[3], bus.irq_pending[3]}, {n < 10, n == 10, n >= 10});
    end

    // Mask, clear and set-beats-clear on channel 2.
    applyStimulus(4'b1011, 4'b0000, 4'b1111);
    cycle();
    check("clr_all", {bus.irq_pending, bus.irq}, 5'd0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    repeat (12) cycle();
    check("ch2_masked", {bus.irq_pending, bus.irq}, {4'b0100, 1'b0});
    applyStimulus(4'b1111, 4'b0100, 4'b0000);
    cycle();
    check("ch2_unmask", bus.irq, 1'b1);
    applyStimulus(4'b1011, 4'b0100, 4'b0000);
    repeat (12) cycle();
    check("ch2_fall_keeps", {bus.level[2], bus.irq_pending[2]}, 2'b01);
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(4'b1111, 4'b0100, (n == 10) ? 4'b0100 : 4'b0000);
      cycle();
      if (n == 10) check("set_beats_clear", {bus.rise[2], bus.irq_pending[2], bus.irq}, 3'b111);
    end
    applyStimulus(4'b1111, 4'b0100, 4'b0100);
    cycle();
    check("lone_clear", {bus.irq_pending[2], bus.irq}, 2'b00);

    // Reset mid-count: full window needed after release.
    applyStimulus(4'b1010, 4'b1111, 4'b0000);
    repeat (12) cycle();
    applyStimulus(4'b1011, 4'b1111, 4'b0000);
    repeat (5) cycle();
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("rst_ch0", {bus.level[0], bus.rise[0]}, {n >= 10, n == 10});
    end

    // Table-driven steps from a clean reset.
    applyStimulus(4'b1000, 4'b1111, 4'b0000);
    do_reset();
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].in_raw, vecs[v].mask, vecs[v].clr);
      repeat (vecs[v].cycles) cycle();
      check($sformatf("vec%0d", v), {bus.level, bus.irq_pending, bus.irq},
            {vecs[v].exp_level, vecs[v].exp_pend, vecs[v].exp_irq});
    end

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] r, clr;
      r = bus.in_raw;
      clr = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
        if ($urandom_range(0, 7) == 0) clr[i] = 1'b1;
      end
      applyStimulus(r, 4'($urandom_range(0, 15)), clr);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_debounce_irq.md
Name: gpio_debounce_irq

Overview:
- Parametrised N-channel input conditioner for board switches and keys, feeding the FlexPRET GPIO-in and external-interrupt ports.
- Per channel: 2-flop synchroniser, optional polarity inversion, counter-based debounce, registered rise/fall pulses, and a sticky interrupt-pending latch with clear and mask.
- Replaces direct wiring of raw SW/KEY pins into the core in the board top.

Parameters:
- N_CH, 4, number of input channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be >= 1; counter width = clog2(DEBOUNCE_CYCLES+1), localparam.
- INVERT, {N_CH{1'b0}}, per-channel bitmask. A 1 inverts the raw pin (active-low keys) before debounce.
- IRQ_RISE, {N_CH{1'b1}}, per-channel bitmask: a debounced rise sets pending.
- IRQ_FALL, {N_CH{1'b0}}, per-channel bitmask: a debounced fall sets pending.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- in_raw  in  N_CH  asynchronous raw pins.
- irq_mask  in  N_CH  1 = channel may drive irq.
- irq_clear  in  N_CH  per-channel clear of pending, level-sensitive per cycle.
- level  out  N_CH  debounced, polarity-corrected level.
- rise  out  N_CH  one-cycle pulse on accepted 0->1.
- fall  out  N_CH  one-cycle pulse on accepted 1->0.
- irq_pending  out  N_CH  sticky pending flags.
- irq  out  1  OR of (irq_pending & irq_mask).

Behaviour:
- Reset (reset=0, async assert; deassertion sampled by clock):
  - sync0[i] and sync1[i] reset to INVERT[i], so the corrected sample is 0 and no edge occurs after reset.
  - level, rise, fall, irq_pending reset to 0; all counters reset to 0; irq resets to 0.
- Synchroniser: sync0 <= in_raw; sync1 <= sync0. Corrected sample s[i] = sync1[i] ^ INVERT[i].
- Debounce, per channel, each cycle:
  - s == level: cnt <= 0.
  - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s; cnt <= 0; rise <= s; fall <= ~s.
  - s != level otherwise: cnt <= cnt+1.
  - rise and fall are 0 on every cycle without an accepted change.
  - A mismatch that lasts fewer than DEBOUNCE_CYCLES cycles never changes level; any cycle with s == level restarts the count.
- Latency: a raw change stable from clock edge k gives a level change at edge k+1+DEBOUNCE_CYCLES. It appears in sync1 after edge k+1 and needs DEBOUNCE_CYCLES mismatching cycles. rise/fall assert in the same cycle that level changes.
- Pending latch, per channel, each cycle:
  - set = (rise & IRQ_RISE) | (fall & IRQ_FALL).
  - pending <= set ? 1 : (irq_clear ? 0 : pending). When set and clear coincide, set wins.
  - irq_mask does not gate the latch; a masked channel still records pending.
  - irq is registered: irq <= |(pending_next & irq_mask). irq therefore asserts in the same cycle as the pending flag.
- Channels are fully independent; simultaneous events on different channels are each handled in the same cycle.
- Reset asserted mid-count abandons the count and returns to reset values. No edge is reported for a pin held non-idle through reset until debounce completes after release.
- No combinational path from inputs to outputs.

Test Plan:
- Bench uses N_CH=4, DEBOUNCE_CYCLES=8, INVERT=4'b1000, IRQ_RISE=4'b0111, IRQ_FALL=4'b1001.
- Reset, then in_raw=4'b1000 held -> level=0, rise=fall=irq_pending=0, irq=0 for 50 cycles.
- in_raw[0] 0->1 at edge k and held -> level[0]=1 and rise[0]=1 exactly at edge k+9. rise[0] is 1 for 1 cycle. irq_pending[0]=1, and irq=1 if irq_mask[0]=1. No further pulse follows.
- in_raw[1] toggled with 5-cycle high and 5-cycle low pulses for 100 cycles -> level[1] stays 0, rise[1] never asserts, pending[1] stays 0. Then hold high 8+ cycles -> accepted at k+9.
- Channel 3 (inverted, key press): in_raw[3] 1->0 and held -> level[3]=1 at k+9. Release 1 -> fall[3] pulse at release edge+9, pending[3]=1 via IRQ_FALL.
- irq_mask=0, trigger ch2 rise -> pending[2]=1, irq=0. Set irq_mask[2]=1 -> irq=1 next cycle. Pulse irq_clear[2] on the same cycle as a new rise[2] -> pending stays 1. A lone clear -> pending 0, irq 0.
- Raw ch0 high for 5 cycles, then reset pulsed low, then released with raw still high -> after release, level[0]=1 only after a full 9-cycle window. No early pulse occurs.
